bnn_operand_loader: RTL and testbench
=====================================

BNN_OPERAND_LOADER -- requirements
Module: bnn_operand_loader

Interface
REQ-001 The block SHALL have one parameter: NBYTES, default 4, bytes per operand word; operand width W = 8*NBYTES (32 at default).
REQ-002 The block SHALL have the following ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear of the frame in progress and the output slot.
- in_byte  in  8  operand byte.
- in_is_weight  in  1  tag on in_byte: 1 = weight byte, 0 = input-data byte.
- in_valid  in  1  in_byte and in_is_weight are valid.
- in_ready  out  1  block accepts a byte this cycle.
- input_data  out  W  assembled input vector, to the neuron stage.
- weight  out  W  assembled weight vector, to the neuron stage.
- out_valid  out  1  input_data/weight hold a complete frame.
- out_ready  in  1  downstream consumes the frame this cycle.
- seq_err  out  1  one-cycle pulse: byte rejected due to a tag/phase mismatch.
- frames_done  out  8  count of frames transferred to the output slot.

Function
REQ-003 A byte SHALL be accepted on a rising edge where in_valid && in_ready.
REQ-004 A frame SHALL be NBYTES input-data bytes followed by NBYTES weight bytes, little-endian: the k-th byte of each word (k = 0..NBYTES-1) lands in bits [8k+7:8k].
REQ-005 The FSM SHALL have three states: LOAD_X, LOAD_W and HOLD, with a byte index 0..NBYTES-1.
REQ-006 State LOAD_X: in_ready=1. An accepted byte with tag 0 is written to assembly-X[idx].
- If idx == NBYTES-1: idx<=0, go to LOAD_W.
- Otherwise: idx++.
REQ-007 State LOAD_W: in_ready=1. An accepted byte with tag 1 is written to assembly-W[idx].
- If idx == NBYTES-1: idx<=0, go to HOLD.
- Otherwise: idx++.
REQ-008 On a tag mismatch in LOAD_X or LOAD_W (tag 1 in LOAD_X, tag 0 in LOAD_W), the block SHALL:
- accept and discard the byte;
- pulse seq_err high for the following cycle;
- return to LOAD_X with idx=0, leaving the output slot untouched.
REQ-009 State HOLD: in_ready=0. When (!out_valid || out_ready), the block SHALL in the same edge:
- copy assembly-X to input_data and assembly-W to weight;
- set out_valid<=1;
- increment frames_done;
- go to LOAD_X.
Otherwise it SHALL stay in HOLD.
REQ-010 Latency: last weight byte accepted at edge N, with the slot free or consumed at edge N+1, gives out_valid=1 and new data after edge N+1.
REQ-011 input_data and weight SHALL change only on a HOLD transfer; they remain stable while out_valid=1 and out_ready=0.
REQ-012 out_valid SHALL clear on an edge where out_valid && out_ready and no HOLD transfer occurs on that edge.
REQ-013 On a simultaneous consume and transfer, out_valid SHALL stay 1 and the new frame SHALL replace the old one with no bubble.
REQ-014 Assembly of the next frame SHALL proceed in LOAD_X/LOAD_W while the output slot is occupied (double buffering).
REQ-015 frames_done SHALL wrap from 255 to 0.
REQ-016 flush SHALL take priority over all other activity and, on the edge where it is sampled high, SHALL:
- set state LOAD_X, idx=0;
- clear the assembly registers;
- set out_valid=0;
- leave input_data, weight and frames_done unchanged;
- set seq_err=0.
No byte is accepted on a flush edge.
REQ-017 Data values SHALL not be interpreted; no arithmetic SHALL be applied to operands.

Reset
REQ-018 While reset=1, the following SHALL hold asynchronously:
- state LOAD_X, idx=0;
- assembly registers, input_data and weight = 0;
- out_valid=0, seq_err=0, frames_done=0;
- in_ready=1 after reset deasserts.
REQ-019 A reset assertion mid-frame or mid-HOLD SHALL discard all partial and pending data; the first frame after release SHALL start at byte 0.

Verification
REQ-020 Basic frame: out_ready=1; send X bytes 0x11,0x22,0x33,0x44 then W bytes 0xAA,0xBB,0xCC,0xDD back-to-back. Required response:
- input_data=0x44332211, weight=0xDDCCBBAA;
- out_valid high one edge after the last byte, for 1 cycle;
- frames_done=1.
REQ-021 Backpressure: out_ready=0; send frame A (0x01..0x08) then frame B (0x10..0x17). Required response:
- frame A is presented and held;
- B assembles, then in HOLD in_ready=0;
- on raising out_ready for 1 cycle, B replaces A with out_valid continuous;
- frames_done=2.
REQ-022 Sequence error: send 2 X bytes, then a byte tagged weight. Required response:
- seq_err pulses for 1 cycle;
- the next 4 X + 4 W bytes (0xF0..0xF7) produce input_data=0xF3F2F1F0, weight=0xF7F6F5F4;
- frames_done increments by 1 only.
REQ-023 Flush and reset: flush asserted after 6 bytes. Required response:
- no frame is produced;
- the next full frame is correct.
Then assert reset while in HOLD. Required response:
- all outputs return to 0, out_valid=0;
- no transfer occurs after release.
REQ-024 Wrap: transfer 256 frames with out_ready=1. Required response:
- frames_done reads 0;
- the 257th frame's data is correct.

Source files
------------

// File: rtl/bnn_operand_loader.sv
// bnn_operand_loader: assembles tagged byte streams into input/weight operand words for the neuron stage.
module bnn_operand_loader #(
  parameter int NBYTES = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic [7:0]            in_byte,
  input  logic                  in_is_weight,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [8*NBYTES-1:0]   input_data,
  output logic [8*NBYTES-1:0]   weight,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  seq_err,
  output logic [7:0]            frames_done
);
  localparam int W = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);
  typedef enum logic [1:0] {LOAD_X, LOAD_W, HOLD} state_t;
  state_t        state_q;
  logic [IW-1:0] idx_q;
  logic [W-1:0]  ax_q, aw_q, input_data_q, weight_q;
  logic          out_valid_q, seq_err_q;
  logic [7:0]    frames_q;
  logic          accept, mismatch, xfer, last;
  assign in_ready    = state_q != HOLD;
  assign accept      = in_valid && in_ready;
  assign mismatch    = accept && (in_is_weight != (state_q == LOAD_W));
  assign xfer        = (state_q == HOLD) && (!out_valid_q || out_ready);
  assign last        = idx_q == LAST;
  assign input_data  = input_data_q;
  assign weight      = weight_q;
  assign out_valid   = out_valid_q;
  assign seq_err     = seq_err_q;
  assign frames_done = frames_q;
  // Frame FSM: byte assembly into the staging words, then hand-off into the output slot.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= LOAD_X;
      idx_q        <= '0;
      ax_q         <= '0;
      aw_q         <= '0;
      input_data_q <= '0;
      weight_q     <= '0;
      out_valid_q  <= 1'b0;
      seq_err_q    <= 1'b0;
      frames_q     <= '0;
    end else if (flush) begin
      state_q     <= LOAD_X;
      idx_q       <= '0;
      ax_q        <= '0;
      aw_q        <= '0;
      out_valid_q <= 1'b0;
      seq_err_q   <= 1'b0;
    end else begin
      seq_err_q <= mismatch;
      if (xfer) begin
        input_data_q <= ax_q;
        weight_q     <= aw_q;
        out_valid_q  <= 1'b1;
        frames_q     <= frames_q + 8'd1;
        state_q      <= LOAD_X;
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (mismatch) begin
        state_q <= LOAD_X;
        idx_q   <= '0;
      end else if (accept) begin
        if (state_q == LOAD_X) ax_q[{idx_q, 3'b000} +: 8] <= in_byte;
        else aw_q[{idx_q, 3'b000} +: 8] <= in_byte;
        idx_q <= last ? '0 : idx_q + 1'b1;
        if (last) state_q <= (state_q == LOAD_X) ? LOAD_W : HOLD;
      end
    end
  end
endmodule

// File: tb/tb_bnn_operand_loader.sv
// tb_bnn_operand_loader: vector table, directed corner sequences and a randomized scoreboard for bnn_operand_loader.
module tb_bnn_operand_loader;
  logic        clock, reset, flush, in_is_weight, in_valid, in_ready, out_valid, out_ready, seq_err;
  logic [7:0]  in_byte, frames_done;
  logic [31:0] input_data, weight;
  int checks = 0;
  int errors = 0;

  bnn_operand_loader #(.NBYTES(4)) dut (
    .clock(clock), .reset(reset), .flush(flush), .in_byte(in_byte),
    .in_is_weight(in_is_weight), .in_valid(in_valid), .in_ready(in_ready),
    .input_data(input_data), .weight(weight), .out_valid(out_valid),
    .out_ready(out_ready), .seq_err(seq_err), .frames_done(frames_done)
  );

  initial clock = 0;
  always #5 clock = ~clock;

  typedef struct {
    logic v, t;
    logic [7:0] b;
    logic r, eov, erdy, ese;
    logic [31:0] ex, ew;
    logic [7:0] ef;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic v, t, input logic [7:0] b, input logic r, eov, erdy, ese,
                     input logic [31:0] ex, ew, input logic [7:0] ef);
    vec_t e;
    e.v = v; e.t = t; e.b = b; e.r = r; e.eov = eov; e.erdy = erdy; e.ese = ese;
    e.ex = ex; e.ew = ew; e.ef = ef;
    tbl.push_back(e);
  endtask

  task automatic send(input logic t, input logic [7:0] b);
    int n = 0;
    in_valid = 1; in_is_weight = t; in_byte = b;
    while (!in_ready && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    if (n >= 50) chk("in_ready_timeout", {63'd0, in_ready}, 64'd1);
    @(posedge clock); #1;
    in_valid = 0;
  endtask

  task automatic frame(input logic [31:0] x, input logic [31:0] w);
    for (int i = 0; i < 4; i++) send(1'b0, x[8*i +: 8]);
    for (int i = 0; i < 4; i++) send(1'b1, w[8*i +: 8]);
  endtask

  task automatic idle(input int n);
    in_valid = 0;
    repeat (n) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic chk_out(input string nm, input logic ov, input logic [31:0] x, w, input logic [7:0] fd);
    chk({nm, "_valid"}, {63'd0, out_valid}, {63'd0, ov});
    chk({nm, "_data"}, {input_data, weight}, {x, w});
    chk({nm, "_frames"}, {56'd0, frames_done}, {56'd0, fd});
  endtask

  initial begin
    logic [31:0] xb, wb;
    logic [63:0] q[$];
    logic [63:0] front;
    int k, nfr, err_exp, err_seen;
    bit ph;
    logic acc, cons;
    reset = 1; flush = 0; in_valid = 0; in_is_weight = 0; in_byte = 0; out_ready = 1;
    repeat (2) @(posedge clock);
    #1;
    chk_out("reset", 0, 0, 0, 0);
    chk("reset_seq_err", {63'd0, seq_err}, 0);
    reset = 0;
    #1;
    chk("reset_in_ready", {63'd0, in_ready}, 1);

    add(1,0,8'h11,1, 0,1,0, 0,0,0);
    add(1,0,8'h22,1, 0,1,0, 0,0,0);
    add(1,0,8'h33,1, 0,1,0, 0,0,0);
    add(1,0,8'h44,1, 0,1,0, 0,0,0);
    add(1,1,8'hAA,1, 0,1,0, 0,0,0);
    add(1,1,8'hBB,1, 0,1,0, 0,0,0);
    add(1,1,8'hCC,1, 0,1,0, 0,0,0);
    add(1,1,8'hDD,1, 0,0,0, 0,0,0);
    add(0,0,8'h00,1, 1,1,0, 32'h44332211,32'hDDCCBBAA,1);
    add(0,0,8'h00,1, 0,1,0, 32'h44332211,32'hDDCCBBAA,1);
    add(1,0,8'h01,1, 0,1,0, 32'h44332211,32'hDDCCBBAA,1);
    add(1,0,8'h02,1, 0,1,0, 32'h44332211,32'hDDCCBBAA,1);
    add(1,1,8'h03,1, 0,1,1, 32'h44332211,32'hDDCCBBAA,1);
    add(0,0,8'h00,1, 0,1,0, 32'h44332211,32'hDDCCBBAA,1);
    for (int i = 0; i < 8; i++)
      add(1, i >= 4, 8'hF0 + 8'(i), 1, 0, i != 7, 0, 32'h44332211, 32'hDDCCBBAA, 1);
    add(0,0,8'h00,1, 1,1,0, 32'hF3F2F1F0,32'hF7F6F5F4,2);
    add(0,0,8'h00,1, 0,1,0, 32'hF3F2F1F0,32'hF7F6F5F4,2);
    foreach (tbl[i]) begin
      in_valid = tbl[i].v; in_is_weight = tbl[i].t; in_byte = tbl[i].b; out_ready = tbl[i].r;
      @(posedge clock); #1;
      chk($sformatf("tbl%0d_valid", i), {63'd0, out_valid}, {63'd0, tbl[i].eov});
      chk($sformatf("tbl%0d_in_ready", i), {63'd0, in_ready}, {63'd0, tbl[i].erdy});
      chk($sformatf("tbl%0d_seq_err", i), {63'd0, seq_err}, {63'd0, tbl[i].ese});
      chk($sformatf("tbl%0d_data", i), {input_data, weight}, {tbl[i].ex, tbl[i].ew});
      chk($sformatf("tbl%0d_frames", i), {56'd0, frames_done}, {56'd0, tbl[i].ef});
    end
    in_valid = 0;

    out_ready = 0;
    frame(32'h04030201, 32'h08070605);
    idle(1);
    chk_out("bp_a", 1, 32'h04030201, 32'h08070605, 3);
    frame(32'h13121110, 32'h17161514);
    chk("bp_hold_in_ready", {63'd0, in_ready}, 0);
    idle(2);
    chk_out("bp_a_held", 1, 32'h04030201, 32'h08070605, 3);
    out_ready = 1;
    @(posedge clock); #1;
    chk_out("bp_b", 1, 32'h13121110, 32'h17161514, 4);
    out_ready = 0;
    idle(1);
    chk_out("bp_b_held", 1, 32'h13121110, 32'h17161514, 4);
    out_ready = 1;
    idle(1);
    chk_out("bp_drain", 0, 32'h13121110, 32'h17161514, 4);

    out_ready = 0;
    frame(32'h23222120, 32'h27262524);
    idle(1);
    chk_out("fl_c", 1, 32'h23222120, 32'h27262524, 5);
    for (int i = 0; i < 6; i++) send(i >= 4, 8'h30 + 8'(i));
    flush = 1; in_valid = 1; in_is_weight = 0; in_byte = 8'hEE;
    @(posedge clock); #1;
    flush = 0; in_valid = 0;
    chk_out("fl_after", 0, 32'h23222120, 32'h27262524, 5);
    chk("fl_in_ready", {63'd0, in_ready}, 1);
    chk("fl_seq_err", {63'd0, seq_err}, 0);
    out_ready = 1;
    frame(32'h43424140, 32'h47464544);
    idle(1);
    chk_out("fl_next", 1, 32'h43424140, 32'h47464544, 6);
    idle(1);

    out_ready = 0;
    frame(32'h53525150, 32'h57565554);
    idle(1);
    chk_out("rs_e", 1, 32'h53525150, 32'h57565554, 7);
    frame(32'h63626160, 32'h67666564);
    reset = 1;
    #2;
    chk_out("rs_async", 0, 0, 0, 0);
    chk("rs_seq_err", {63'd0, seq_err}, 0);
    @(posedge clock); #1;
    reset = 0; out_ready = 1;
    idle(3);
    chk_out("rs_release", 0, 0, 0, 0);
    chk("rs_in_ready", {63'd0, in_ready}, 1);
    frame(32'h73727170, 32'h77767574);
    idle(1);
    chk_out("rs_first", 1, 32'h73727170, 32'h77767574, 1);

    reset = 1;
    @(posedge clock); #1;
    reset = 0;
    for (int i = 0; i < 256; i++) begin
      frame({4{8'(i)}}, ~{4{8'(i)}});
      idle(1);
    end
    chk("wrap_frames", {56'd0, frames_done}, 0);
    frame(32'hCAFE0001, 32'hBEEF0002);
    idle(1);
    chk_out("wrap_257", 1, 32'hCAFE0001, 32'hBEEF0002, 1);
    idle(1);

    ph = 0; k = 0; nfr = 0; err_exp = 0; err_seen = 0; xb = 0; wb = 0;
    for (int c = 0; c < 1500; c++) begin
      in_valid = ($urandom % 4) != 0;
      in_is_weight = ph ^ (($urandom % 12) == 0);
      in_byte = 8'($urandom);
      out_ready = ($urandom % 3) != 0;
      acc = in_valid && in_ready;
      cons = out_valid && out_ready;
      if (cons) begin
        if (q.size() == 0) chk("rand_spurious_frame", 1, 0);
        else begin
          front = q.pop_front();
          chk("rand_frame", {input_data, weight}, front);
        end
      end
      if (acc) begin
        if (in_is_weight != ph) begin
          err_exp++; ph = 0; k = 0;
        end else begin
          if (!ph) xb[8*k +: 8] = in_byte;
          else wb[8*k +: 8] = in_byte;
          k++;
          if (k == 4) begin
            k = 0;
            if (ph) begin
              q.push_back({xb, wb});
              nfr++;
            end
            ph = !ph;
          end
        end
      end
      @(posedge clock); #1;
      if (seq_err) err_seen++;
    end
    for (int n = 0; n < 40 && q.size() > 0; n++) begin
      in_valid = 0; out_ready = 1;
      if (out_valid) begin
        front = q.pop_front();
        chk("drain_frame", {input_data, weight}, front);
      end
      @(posedge clock); #1;
      if (seq_err) err_seen++;
    end
    chk("rand_pending", 64'(q.size()), 0);
    chk("rand_seq_err_count", 64'(err_seen), 64'(err_exp));
    chk("rand_frames_done", {56'd0, frames_done}, {56'd0, 8'(1 + nfr)});
    chk("rand_final_valid", {63'd0, out_valid}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
